// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and fetch geometry.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: drives pc to memory, registers the returned word into a valid/ready bundle.
// One-cycle fetch latency; a held bundle freezes pc, redirect squashes and restarts from the target.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          LAST_WORD = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run_en,
    output logic [31:0] address,
    input  logic [31:0] instruction,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc,
    output logic [31:0] fetch_count,
    output logic        misalign_err,
    output logic        halted
);

    localparam logic [29:0] LAST_IDX = 30'(LAST_WORD);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         handshake;
    logic         can_take;
    logic         in_range;

    assign address   = pc;
    assign handshake = if_valid && if_ready;
    assign can_take  = !if_valid || if_ready;
    assign in_range  = (pc[31:2] <= LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            pc             <= {RESET_PC[31:2], 2'b00};
            if_valid       <= 1'b0;
            if_instruction <= 32'h0;
            if_pc          <= 32'h0;
            fetch_count    <= 32'h0;
            misalign_err   <= 1'b0;
            halted         <= 1'b0;
        end else begin
            // A handshake on a redirect edge still counts even though the next bundle is squashed.
            if (handshake) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (redirect && (redirect_target[1:0] != 2'b00)) begin
                misalign_err <= 1'b1;
            end

            if (redirect) begin
                pc <= {redirect_target[31:2], 2'b00};
                if (state != IDLE) begin
                    if_valid <= 1'b0;
                    state    <= FETCH;
                    halted   <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (run_en) begin
                            state <= FETCH;
                        end
                    end
                    FETCH, STALL: begin
                        if (can_take) begin
                            if (in_range) begin
                                if_instruction <= instruction;
                                if_pc          <= pc;
                                if_valid       <= 1'b1;
                                pc             <= pc + 32'(INSTR_BYTES);
                                state          <= FETCH;
                            end else begin
                                // Any bundle still out was handshaken on this edge.
                                if_valid <= 1'b0;
                                state    <= HALT;
                                halted   <= 1'b1;
                            end
                        end else begin
                            state <= STALL;
                        end
                    end
                    HALT: begin
                        if (handshake) begin
                            if_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected pcs queued by stimulus, popped on each handshake.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        run_en;
    logic [31:0] address;
    logic [31:0] instruction;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic [31:0] fetch_count;
    logic        misalign_err;
    logic        halted;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb[$];

    fetch_stage #(.RESET_PC(32'h0), .LAST_WORD(17)) dut (
        .clk            (clk),
        .reset          (reset),
        .run_en         (run_en),
        .address        (address),
        .instruction    (instruction),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .fetch_count    (fetch_count),
        .misalign_err   (misalign_err),
        .halted         (halted)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA5C3_0000 ^ (a * 32'h0001_0011);
    endfunction

    assign instruction = mem_word(address);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Handshake monitor: sampled mid-cycle, the values that the next rising edge will see.
    always @(negedge clk) begin
        if (!reset && if_valid && if_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                logic [31:0] epc;
                epc = sb.pop_front();
                check("hs_pc", if_pc, epc);
                check("hs_instr", if_instruction, mem_word(epc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_address"}, address, 32'h0);
        check({pfx, "_if_valid"}, 32'(if_valid), 32'd0);
        check({pfx, "_if_instr"}, if_instruction, 32'h0);
        check({pfx, "_if_pc"}, if_pc, 32'h0);
        check({pfx, "_count"}, fetch_count, 32'h0);
        check({pfx, "_misalign"}, 32'(misalign_err), 32'd0);
        check({pfx, "_halted"}, 32'(halted), 32'd0);
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        run_en          = 1'b0;
        if_ready        = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        check_reset_vals("rst");

        // Straight-line fetch of words 0..3, decode always ready
        sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8); sb.push_back(32'hC);
        run_en = 1'b1; if_ready = 1'b1;
        tick();
        check("idle_to_fetch_no_capture", 32'(if_valid), 32'd0);
        for (int k = 0; k < 5; k++) tick();
        check("run_count4", fetch_count, 32'd4);
        if_ready = 1'b0;

        // Stall holding pc=8
        do_reset();
        sb.push_back(32'h0); sb.push_back(32'h4); sb.push_back(32'h8);
        run_en = 1'b1; if_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        if_ready = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("stall_address", address, 32'hC);
        check("stall_if_pc", if_pc, 32'h8);
        check("stall_if_valid", 32'(if_valid), 32'd1);
        check("stall_count", fetch_count, 32'd2);
        if_ready = 1'b1;
        tick();
        check("unstall_if_pc", if_pc, 32'hC);
        check("unstall_address", address, 32'h10);
        check("unstall_count", fetch_count, 32'd3);
        if_ready = 1'b0;

        // Redirect while stalled at pc=4
        do_reset();
        sb.push_back(32'h0);
        run_en = 1'b1; if_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        if_ready = 1'b0;
        tick();
        check("pre_redir_if_pc", if_pc, 32'h4);
        redirect = 1'b1; redirect_target = 32'h40;
        tick();
        redirect = 1'b0;
        check("redir_squash", 32'(if_valid), 32'd0);
        check("redir_address", address, 32'h40);
        check("redir_count", fetch_count, 32'd1);
        if_ready = 1'b1;
        tick();
        check("redir_if_pc", if_pc, 32'h40);
        check("redir_if_valid", 32'(if_valid), 32'd1);
        if_ready = 1'b0;

        // Run to the last loaded word, halt, then redirect out of HALT
        do_reset();
        for (int w = 0; w <= 17; w++) sb.push_back(32'(w * 4));
        run_en = 1'b1; if_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (!halted && n < 40) begin
                tick();
                n++;
            end
        end
        check("halt_reached", 32'(halted), 32'd1);
        check("halt_if_valid", 32'(if_valid), 32'd0);
        check("halt_address", address, 32'h48);
        check("halt_count", fetch_count, 32'd18);
        check("halt_last_pc", if_pc, 32'h44);
        tick();
        tick();
        check("halt_frozen_addr", address, 32'h48);
        check("halt_stays", 32'(halted), 32'd1);
        redirect = 1'b1; redirect_target = 32'h0;
        tick();
        redirect = 1'b0;
        check("unhalt_halted", 32'(halted), 32'd0);
        check("unhalt_address", address, 32'h0);
        tick();
        check("unhalt_if_pc", if_pc, 32'h0);
        check("unhalt_if_valid", 32'(if_valid), 32'd1);
        // Handshake coinciding with a redirect is still counted
        sb.push_back(32'h0);
        redirect = 1'b1; redirect_target = 32'h8;
        tick();
        redirect = 1'b0; if_ready = 1'b0;
        check("redir_hs_count", fetch_count, 32'd19);
        check("redir_hs_squash", 32'(if_valid), 32'd0);
        check("redir_hs_address", address, 32'h8);

        // Misaligned redirect while IDLE: pc loads, state stays IDLE
        do_reset();
        redirect = 1'b1; redirect_target = 32'h6;
        tick();
        redirect = 1'b0;
        check("mis_address", address, 32'h4);
        check("mis_err", 32'(misalign_err), 32'd1);
        tick();
        tick();
        check("mis_idle_no_capture", 32'(if_valid), 32'd0);
        check("mis_idle_address", address, 32'h4);
        run_en = 1'b1; if_ready = 1'b1;
        tick();
        tick();
        if_ready = 1'b0;
        check("mis_if_pc", if_pc, 32'h4);
        check("mis_err_sticky", 32'(misalign_err), 32'd1);

        // Asynchronous reset mid-stall
        do_reset();
        sb.push_back(32'h0);
        run_en = 1'b1; if_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        if_ready = 1'b0;
        tick();
        check("prearst_count", fetch_count, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("arst");
        tick();
        reset = 1'b0;
        run_en = 1'b0;
        tick();

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock, `clk`, and its reset, `reset`, SHALL be asynchronous and active-high.
REQ-002 Parameter `RESET_PC`, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-003 Parameter `LAST_WORD`, default 17: highest word index holding a loaded instruction.
REQ-004 The ports SHALL be, one per line, name, direction, width and meaning:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- run_en  in  1  level; allows the IDLE state to start fetching.
- address  out  32  byte address driven to the instruction memory.
- instruction  in  32  memory read data, combinational from `address` in the same cycle.
- redirect  in  1  branch/jump taken, single-cycle pulse.
- redirect_target  in  32  new byte address, valid while `redirect` is high.
- if_valid  out  1  output bundle holds a live instruction.
- if_ready  in  1  decode accepts the bundle.
- if_instruction  out  32  registered instruction.
- if_pc  out  32  byte address of `if_instruction`.
- fetch_count  out  32  number of completed handshakes.
- misalign_err  out  1  sticky; set when a redirect target has nonzero bits [1:0].
- halted  out  1  high in the HALT state.

Function
REQ-005 `address` SHALL equal the internal pc register at all times, with bits [1:0] always 0.
REQ-006 The FSM states SHALL be IDLE, FETCH, STALL and HALT; reset enters IDLE.
REQ-007 IDLE SHALL go to FETCH on the first rising clock edge with run_en=1; no capture occurs in IDLE.
REQ-008 A capture happens in FETCH when (!if_valid || if_ready) and pc[31:2] <= LAST_WORD. On that edge: if_instruction<=instruction, if_pc<=pc, if_valid<=1, pc<=pc+4.
REQ-009 The fetch latency SHALL be one cycle: an instruction presented on `address` appears on `if_instruction` on the next edge.
REQ-010 When if_valid=1 and if_ready=0, the FSM SHALL move to (or stay in) STALL, with pc and the bundle frozen.
REQ-011 STALL SHALL return to FETCH on the edge where if_ready=1; a capture SHALL occur on that same edge, giving no bubble.
REQ-012 A handshake SHALL be if_valid && if_ready at a rising edge; fetch_count increments by 1 per handshake and wraps modulo 2^32.
REQ-013 When FETCH would capture but pc[31:2] > LAST_WORD, the FSM SHALL go to HALT with no capture.
- A pending bundle remains valid until its handshake completes, then if_valid drops.
REQ-014 redirect has highest priority, in any state other than IDLE:
- pc <= {redirect_target[31:2], 2'b00}.
- if_valid <= 0; the bundle is squashed.
- The FSM goes to FETCH, which also leaves HALT.
REQ-015 A handshake completing on the same edge as redirect SHALL still be counted.
REQ-016 redirect in IDLE SHALL load pc only, with the state unchanged.
REQ-017 misalign_err SHALL set on any redirect with redirect_target[1:0] != 0 and clear only on reset.
REQ-018 pc+4 SHALL wrap modulo 2^32, with no error.
REQ-019 halted SHALL be 1 exactly while the state is HALT.

Reset
REQ-020 While reset is high, the following SHALL hold, asynchronously:
- state = IDLE, pc = RESET_PC.
- if_valid = 0, if_instruction = 0, if_pc = 0.
- fetch_count = 0, misalign_err = 0, halted = 0.
REQ-021 Reset asserted mid-stall or mid-fetch SHALL discard the held bundle with no handshake counted.
REQ-022 The first capture after reset release SHALL occur no earlier than the edge following the IDLE-to-FETCH transition.

Structure
REQ-023 A shared package SHALL hold:
- the state encoding (IDLE, FETCH, STALL, HALT);
- INSTR_BYTES = 4;
- the default RESET_PC.
REQ-024 The block SHALL be a single module with no sub-modules; the pc register and the output register live inline.

Verification
REQ-025 Reset, then run_en=1 with if_ready held at 1 and memory words 0..3 = A,B,C,D -> if_pc = 0,4,8,12 on consecutive cycles with instructions A..D and fetch_count = 4.
REQ-026 if_ready=0 for 3 cycles while the bundle holds pc=8 -> address stays 12 and the bundle is unchanged; when if_ready rises, pc=12 is captured on the same edge.
REQ-027 Pulse redirect with target 32'h40 while a bundle at pc=4 is stalled -> if_valid=0 the next cycle, address=0x40, and the following if_pc=0x40.
REQ-028 Run to word 17 with LAST_WORD=17 -> if_pc=0x44 is delivered and accepted, then halted=1, if_valid=0 and address=0x48 is frozen; a redirect to 0 resumes fetching.
REQ-029 Redirect with target 32'h0000_0006 -> address=0x04 and misalign_err=1, which stays set until reset.
REQ-030 Assert reset asynchronously mid-STALL -> all outputs reach their reset values before the next edge and fetch_count = 0.
